// File: rtl/mini_src_control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, opcode-class execute T3-T7,
// memory wait handshake with timeout, halt/run control.
module mini_src_control_sequencer #(
  parameter int OPCODE_W    = 5,
  parameter int STEP_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                run,
  input  logic [OPCODE_W-1:0] ir_op,
  input  logic                CON_FF,
  input  logic                mem_done,
  output logic                PCout,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                MDRout,
  output logic                MARin,
  output logic                Zin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                LOin,
  output logic                HIin,
  output logic                IncPC,
  output logic                Read,
  output logic                Write,
  output logic                GRA,
  output logic                GRB,
  output logic                GRC,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Cout,
  output logic [OPCODE_W-1:0] alu_op,
  output logic                halted,
  output logic                mem_err,
  output logic [STEP_W-1:0]   step
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(3);

  // State encoding doubles as the step debug value.
  typedef enum logic [3:0] {
    S_T0 = 4'd0, S_T1 = 4'd1, S_T2 = 4'd2, S_T3 = 4'd3,
    S_T4 = 4'd4, S_T5 = 4'd5, S_T6 = 4'd6, S_T7 = 4'd7,
    S_IDLE = 4'd14, S_HALT = 4'd15
  } state_t;

  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_RALU, C_IALU, C_MD, C_BRX, C_JR, C_JAL, C_HALT, C_NOP
  } cls_t;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin;
    logic HIin, IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout;
  } ctrl_t;

  function automatic cls_t decode(input logic [OPCODE_W-1:0] op);
    cls_t c;
    if (op == OPCODE_W'(0))                              c = C_LD;
    else if (op == OPCODE_W'(1))                         c = C_LDI;
    else if (op == OPCODE_W'(2))                         c = C_ST;
    else if (op >= OPCODE_W'(3)  && op <= OPCODE_W'(11)) c = C_RALU;
    else if (op >= OPCODE_W'(12) && op <= OPCODE_W'(14)) c = C_IALU;
    else if (op == OPCODE_W'(15) || op == OPCODE_W'(16)) c = C_MD;
    else if (op == OPCODE_W'(19))                        c = C_BRX;
    else if (op == OPCODE_W'(20))                        c = C_JR;
    else if (op == OPCODE_W'(21))                        c = C_JAL;
    else if (op == OPCODE_W'(27))                        c = C_HALT;
    else                                                 c = C_NOP;
    return c;
  endfunction

  state_t              state, nxt;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    wait_cnt;
  logic                err_q, err_set, last, wait_step;
  cls_t                cls;
  ctrl_t               c;
  logic [OPCODE_W-1:0] alu_n;

  // IR is only guaranteed from T3; latch it there so later steps see a stable class.
  assign cls = (state == S_T3) ? decode(ir_op) : decode(op_q);

  always_ff @(posedge Clock) begin
    if (clear) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= nxt;
      if (state == S_T3) op_q <= ir_op;
      wait_cnt <= (wait_step && !mem_done) ? wait_cnt + 1'b1 : '0;
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    c         = '0;
    alu_n     = '0;
    last      = 1'b0;
    wait_step = 1'b0;
    case (state)
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      S_T1: begin
        c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1;
        wait_step = 1'b1;
      end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3: case (cls)
        C_LD, C_LDI, C_ST: begin c.GRB = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
        C_RALU, C_IALU:    begin c.GRB = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
        C_MD:              begin c.GRA = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
        C_BRX:             begin c.GRA = 1'b1; c.Rout = 1'b1; end
        C_JR:              begin c.GRA = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; last = 1'b1; end
        C_JAL:             begin c.PCout = 1'b1; c.Rin = 1'b1; end  // R15 via all GR selects low
        C_HALT:            ;
        default:           last = 1'b1;
      endcase
      S_T4: case (cls)
        C_LD, C_LDI, C_ST: begin c.Cout = 1'b1; c.Zin = 1'b1; alu_n = OP_ADD; end
        C_RALU:  begin c.GRC = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; alu_n = op_q; end
        C_IALU:  begin c.Cout = 1'b1; c.Zin = 1'b1; alu_n = op_q; end
        C_MD:    begin c.GRB = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; alu_n = op_q; end
        C_BRX:   begin c.PCout = 1'b1; c.Yin = 1'b1; end
        C_JAL:   begin c.GRA = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; last = 1'b1; end
        default: last = 1'b1;
      endcase
      S_T5: case (cls)
        C_LD, C_ST:             begin c.Zlowout = 1'b1; c.MARin = 1'b1; end
        C_LDI, C_RALU, C_IALU: begin
          c.Zlowout = 1'b1; c.GRA = 1'b1; c.Rin = 1'b1; last = 1'b1;
        end
        C_MD:    begin c.Zlowout = 1'b1; c.LOin = 1'b1; end
        C_BRX:   begin c.Cout = 1'b1; c.Zin = 1'b1; alu_n = OP_ADD; end
        default: last = 1'b1;
      endcase
      S_T6: case (cls)
        C_LD:    begin c.Read = 1'b1; c.MDRin = 1'b1; wait_step = 1'b1; end
        C_ST:    begin c.GRA = 1'b1; c.Rout = 1'b1; c.MDRin = 1'b1; end
        C_MD:    begin c.Zhighout = 1'b1; c.HIin = 1'b1; last = 1'b1; end
        C_BRX:   begin c.Zlowout = CON_FF; c.PCin = CON_FF; last = 1'b1; end
        default: last = 1'b1;
      endcase
      S_T7: case (cls)
        C_LD:    begin c.MDRout = 1'b1; c.GRA = 1'b1; c.Rin = 1'b1; last = 1'b1; end
        C_ST:    begin c.Write = 1'b1; wait_step = 1'b1; last = 1'b1; end
        default: last = 1'b1;
      endcase
      default: ;
    endcase
  end

  always_comb begin
    nxt     = state;
    err_set = 1'b0;
    case (state)
      S_IDLE: if (run) nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: begin
        if (state == S_T3 && cls == C_HALT) begin
          nxt = S_HALT;
        end else if (wait_step && !mem_done) begin
          // Stalled cycle: hold unless this one exhausts the wait budget.
          if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            nxt     = S_HALT;
            err_set = 1'b1;
          end
        end else if (last) begin
          nxt = run ? S_T0 : S_IDLE;
        end else begin
          nxt = state_t'(state + 4'd1);
        end
      end
    endcase
  end

  assign PCout    = c.PCout;
  assign Zlowout  = c.Zlowout;
  assign Zhighout = c.Zhighout;
  assign MDRout   = c.MDRout;
  assign MARin    = c.MARin;
  assign Zin      = c.Zin;
  assign PCin     = c.PCin;
  assign MDRin    = c.MDRin;
  assign IRin     = c.IRin;
  assign Yin      = c.Yin;
  assign LOin     = c.LOin;
  assign HIin     = c.HIin;
  assign IncPC    = c.IncPC;
  assign Read     = c.Read;
  assign Write    = c.Write;
  assign GRA      = c.GRA;
  assign GRB      = c.GRB;
  assign GRC      = c.GRC;
  assign Rin      = c.Rin;
  assign Rout     = c.Rout;
  assign BAout    = c.BAout;
  assign Cout     = c.Cout;
  assign alu_op   = alu_n;
  assign halted   = (state == S_HALT);
  assign mem_err  = err_q;
  assign step     = STEP_W'(state);

endmodule

// File: tb/tb_mini_src_control_sequencer.sv
// Bench for mini_src_control_sequencer: an expected per-cycle trace is built from the
// instruction step tables, then replayed against the DUT cycle by cycle.
module tb_mini_src_control_sequencer;
  logic Clock = 1'b0;
  logic clear = 1'b0, run = 1'b0, CON_FF = 1'b0, mem_done = 1'b0;
  logic [4:0] ir_op = '0;
  logic PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin;
  logic HIin, IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout;
  logic [4:0] alu_op;
  logic halted, mem_err;
  logic [3:0] step;
  logic [21:0] strobes;

  always #5 Clock = ~Clock;

  mini_src_control_sequencer #(.OPCODE_W(5), .STEP_W(4), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .clear(clear), .run(run), .ir_op(ir_op), .CON_FF(CON_FF),
    .mem_done(mem_done), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
    .Write(Write), .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Cout(Cout), .alu_op(alu_op), .halted(halted),
    .mem_err(mem_err), .step(step)
  );

  assign strobes = {Cout, BAout, Rout, Rin, GRC, GRB, GRA, Write, Read, IncPC, HIin,
                    LOin, Yin, IRin, MDRin, PCin, Zin, MARin, MDRout, Zhighout,
                    Zlowout, PCout};

  localparam logic [21:0] PCOUT = 22'd1 << 0,  ZLO   = 22'd1 << 1,  ZHI   = 22'd1 << 2;
  localparam logic [21:0] MDROUT= 22'd1 << 3,  MARIN = 22'd1 << 4,  ZIN   = 22'd1 << 5;
  localparam logic [21:0] PCIN  = 22'd1 << 6,  MDRIN = 22'd1 << 7,  IRIN  = 22'd1 << 8;
  localparam logic [21:0] YIN   = 22'd1 << 9,  LOIN  = 22'd1 << 10, HIIN  = 22'd1 << 11;
  localparam logic [21:0] INCPC = 22'd1 << 12, READ  = 22'd1 << 13, WRITE = 22'd1 << 14;
  localparam logic [21:0] GRA_M = 22'd1 << 15, GRB_M = 22'd1 << 16, GRC_M = 22'd1 << 17;
  localparam logic [21:0] RIN   = 22'd1 << 18, ROUT  = 22'd1 << 19, BAOUT = 22'd1 << 20;
  localparam logic [21:0] COUT  = 22'd1 << 21;
  localparam logic [21:0] BUS   = PCOUT | ZLO | ZHI | MDROUT | ROUT | COUT;

  typedef struct {
    int          step;
    logic [21:0] m;
    logic [4:0]  alu;
    logic [4:0]  ir;
    bit          md, run, con, hlt, err, clr, chk;
  } cyc_t;

  cyc_t q[$];
  logic [4:0] g_ir;
  bit g_con, g_err;
  int n_cmp = 0, n_bad = 0;

  task automatic push(input int st, input logic [21:0] m, input logic [4:0] alu,
                      input bit md, input bit rn);
    cyc_t c;
    c.step = st; c.m = m; c.alu = alu;
    c.ir   = (st >= 3 && st <= 7) ? g_ir : 5'($urandom);
    c.md = md; c.run = rn; c.con = g_con; c.hlt = (st == 15); c.err = g_err;
    c.clr = 1'b0; c.chk = 1'b1;
    q.push_back(c);
  endtask

  // Memory step: 'stalls' cycles with mem_done low, then the completing cycle.
  task automatic wstep(input int st, input logic [21:0] m, input logic [4:0] alu,
                       input int stalls);
    for (int i = 0; i < stalls; i++) push(st, m, alu, 1'b0, 1'($urandom));
    push(st, m, alu, 1'b1, 1'($urandom));
  endtask

  task automatic add_instr(input logic [4:0] op, input bit con, input int s1,
                           input int s2, input int gap, input bit abort);
    logic [21:0] ex[$];
    logic [4:0]  al[$];
    int wt = -1;
    g_ir  = op;
    g_con = (op == 5'd19) ? con : 1'($urandom);
    push(0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'($urandom), 1'($urandom));
    wstep(1, ZLO | PCIN | READ | MDRIN, 5'd0, s1);
    push(2, MDROUT | IRIN, 5'd0, 1'($urandom), 1'($urandom));
    if (op <= 5'd2) begin
      ex = '{GRB_M | BAOUT | YIN, COUT | ZIN}; al = '{5'd0, 5'd3};
      if (op == 5'd0) begin
        ex.push_back(ZLO | MARIN); ex.push_back(READ | MDRIN); ex.push_back(MDROUT | GRA_M | RIN);
        al.push_back(0); al.push_back(0); al.push_back(0); wt = 6;
      end else if (op == 5'd1) begin
        ex.push_back(ZLO | GRA_M | RIN); al.push_back(0);
      end else begin
        ex.push_back(ZLO | MARIN); ex.push_back(GRA_M | ROUT | MDRIN); ex.push_back(WRITE);
        al.push_back(0); al.push_back(0); al.push_back(0); wt = 7;
      end
    end else if (op <= 5'd11) begin
      ex = '{GRB_M | ROUT | YIN, GRC_M | ROUT | ZIN, ZLO | GRA_M | RIN}; al = '{5'd0, op, 5'd0};
    end else if (op <= 5'd14) begin
      ex = '{GRB_M | ROUT | YIN, COUT | ZIN, ZLO | GRA_M | RIN}; al = '{5'd0, op, 5'd0};
    end else if (op <= 5'd16) begin
      ex = '{GRA_M | ROUT | YIN, GRB_M | ROUT | ZIN, ZLO | LOIN, ZHI | HIIN};
      al = '{5'd0, op, 5'd0, 5'd0};
    end else if (op == 5'd19) begin
      ex = '{GRA_M | ROUT, PCOUT | YIN, COUT | ZIN, con ? (ZLO | PCIN) : 22'd0};
      al = '{5'd0, 5'd0, 5'd3, 5'd0};
    end else if (op == 5'd20) begin
      ex = '{GRA_M | ROUT | PCIN}; al = '{5'd0};
    end else if (op == 5'd21) begin
      ex = '{PCOUT | RIN, GRA_M | ROUT | PCIN}; al = '{5'd0, 5'd0};
    end else begin
      ex = '{22'd0}; al = '{5'd0};
    end
    for (int i = 0; i < ex.size(); i++) begin
      if (3 + i == wt) wstep(3 + i, ex[i], al[i], s2);
      else push(3 + i, ex[i], al[i], 1'($urandom), 1'($urandom));
    end
    if (op == 5'd27) begin
      // Halt is sticky: run is ignored until clear.
      for (int i = 0; i < 2 + gap; i++) push(15, 22'd0, 5'd0, 1'($urandom), 1'b1);
      q[q.size()-1].clr = 1'b1;
      push(14, 22'd0, 5'd0, 1'($urandom), 1'b1);
    end else if (abort) begin
      q[q.size()-1].clr = 1'b1;
      push(14, 22'd0, 5'd0, 1'($urandom), 1'b1);
    end else if (gap == 0) begin
      q[q.size()-1].run = 1'b1;
    end else begin
      q[q.size()-1].run = 1'b0;
      for (int i = 0; i < gap - 1; i++) push(14, 22'd0, 5'd0, 1'($urandom), 1'b0);
      push(14, 22'd0, 5'd0, 1'($urandom), 1'b1);
    end
  endtask

  task automatic add_timeout();
    g_ir = 5'($urandom); g_con = 1'($urandom);
    push(0, PCOUT | MARIN | INCPC | ZIN, 5'd0, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 15; i++) push(1, ZLO | PCIN | READ | MDRIN, 5'd0, 1'b0, 1'($urandom));
    g_err = 1'b1;
    for (int i = 0; i < 3; i++) push(15, 22'd0, 5'd0, 1'($urandom), 1'b1);
    q[q.size()-1].clr = 1'b1;
    g_err = 1'b0;
    push(14, 22'd0, 5'd0, 1'($urandom), 1'b1);
  endtask

  initial begin
    logic [32:0] obs, exp;
    g_err = 1'b0; g_con = 1'b0; g_ir = '0;
    push(14, 22'd0, 5'd0, 1'b0, 1'b0); q[0].clr = 1'b1; q[0].chk = 1'b0;
    push(14, 22'd0, 5'd0, 1'b0, 1'b0); q[1].clr = 1'b1;
    push(14, 22'd0, 5'd0, 1'b0, 1'b1);

    add_instr(5'b00011, 1'b0, 0, 0, 0, 1'b0);   // add
    add_instr(5'b00000, 1'b0, 0, 3, 0, 1'b0);   // ld, 3 stalls in T6
    add_instr(5'b10011, 1'b0, 0, 0, 0, 1'b0);   // brx not taken
    add_instr(5'b10011, 1'b1, 0, 0, 1, 1'b0);   // brx taken
    add_instr(5'b00010, 1'b0, 2, 1, 0, 1'b0);   // st
    add_instr(5'b11111, 1'b0, 0, 0, 0, 1'b0);   // undefined
    add_instr(5'b00010, 1'b0, 0, 2, 0, 1'b1);   // st, cleared in T7
    add_instr(5'b11011, 1'b0, 0, 0, 1, 1'b0);   // halt
    add_timeout();
    for (int n = 0; n < 40; n++)
      add_instr(5'($urandom_range(0, 31)), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                $urandom_range(0, 9) == 0);
    add_timeout();

    for (int i = 0; i < q.size(); i++) begin
      @(negedge Clock);
      clear = q[i].clr; run = q[i].run; ir_op = q[i].ir;
      CON_FF = q[i].con; mem_done = q[i].md;
      #1;
      if (q[i].chk) begin
        exp = {4'(q[i].step), q[i].m, q[i].alu, q[i].hlt, q[i].err};
        obs = {step, strobes, alu_op, halted, mem_err};
        n_cmp++;
        assert (obs === exp) else begin
          n_bad++;
          $error("FAIL trace cyc%0d {step,strobes,alu,halted,err}: observed=%h required=%h",
                 i, obs, exp);
        end
        n_cmp++;
        assert ($countones(strobes & BUS) <= 1) else begin
          n_bad++;
          $error("FAIL busdrv cyc%0d: observed=%h required=at most one driver", i, strobes & BUS);
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mini_src_control_sequencer.md
Name:
mini_src_control_sequencer

Overview:
- Hardwired control unit for the Mini SRC datapath; replaces hand-sequenced T-state stimulus with a synthesizable FSM.
- Steps fetch (T0–T2) and execute (T3–T7) per opcode class and drives every datapath control strobe.
- Adds a memory wait handshake, a timeout, and a conditional branch on CON_FF.
- Supports halt/run control.
- Sits between the memory/IR subsystem and the Datapath control inputs.

Parameters:
- OPCODE_W, 5, width of IR opcode field and alu_op.
- STEP_W, 4, width of step debug output (must encode 0..7 plus IDLE/HALT).
- MEM_TIMEOUT, 15, max cycles a Read/Write step may wait for mem_done before error.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- run  in  1  start request, sampled in IDLE.
- ir_op  in  OPCODE_W  opcode from IR[31:27], valid from T3.
- CON_FF  in  1  branch-condition flag from CON logic.
- mem_done  in  1  memory access complete.
- PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin, IncPC, Read, Write, GRA, GRB, GRC, Rin, Rout, BAout, Cout  out  1 each  datapath control strobes.
- alu_op  out  OPCODE_W  ALU operation code.
- halted  out  1  processor stopped.
- mem_err  out  1  sticky timeout flag.
- step  out  STEP_W  current T-state: 0..7; 14 = IDLE; 15 = HALT.

Behaviour:
- Reset: on Clock edge with clear=1, state=IDLE, wait counter=0, mem_err=0. Strobes are a Moore decode of state, so all strobes, halted and alu_op read 0 from the first cycle after reset; step=14.
- clear overrides everything, including mid-instruction and mid-wait. No partial strobes after it.
- IDLE: all strobes 0. Goes to T0 on the cycle after run=1 is sampled.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute, selected by ir_op in T3:
  - ld (00000), ldi (00001):
    - T3: GRB, BAout, Yin.
    - T4: Cout, Zin, alu_op=ADD(00011).
    - T5: Zlowout. For ld also MARin. For ldi also GRA, Rin, then end.
    - T6 (ld only): Read, MDRin.
    - T7 (ld only): MDRout, GRA, Rin.
  - st (00010):
    - T3–T4: as ld.
    - T5: Zlowout, MARin.
    - T6: GRA, Rout, MDRin.
    - T7: Write.
  - R-type ALU (00011–01011):
    - T3: GRB, Rout, Yin.
    - T4: GRC, Rout, Zin, alu_op=ir_op.
    - T5: Zlowout, GRA, Rin.
  - Immediate ALU (01100–01110):
    - T3: as R-type.
    - T4: Cout, Zin, alu_op=ir_op.
    - T5: as R-type.
  - mul/div (01111, 10000):
    - T3: GRA, Rout, Yin.
    - T4: GRB, Rout, Zin, alu_op=ir_op.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - brx (10011):
    - T3: GRA, Rout (drives CON logic).
    - T4: PCout, Yin.
    - T5: Cout, Zin, alu_op=ADD.
    - T6: if CON_FF=1 (sampled in T6), Zlowout and PCin; else no strobes.
  - jr (10100): T3: GRA, Rout, PCin.
  - jal (10101):
    - T3: PCout, Rin, with R15 selected by GRB=0/GRA=0/GRC=0 and Rin alone (datapath convention).
    - T4: GRA, Rout, PCin.
  - nop (11010) and any undefined opcode: T3 with no strobes, then end.
  - halt (11011): T3 enters HALT. halted=1, all strobes 0. HALT is sticky until clear.
- End of sequence: from the last listed step, go to T0 next cycle if run=1, else IDLE.
- Memory wait: in T1, ld T6 and st T7, the state holds and strobes stay asserted while mem_done=0. The FSM advances on the edge where mem_done=1. mem_done=1 on the first cycle gives zero extra cycles.
- Wait counter: counts stalled cycles and clears on advance. If it reaches MEM_TIMEOUT with mem_done still 0, set mem_err=1 and go to HALT.
- mem_done outside wait steps is ignored.
- Latency with mem_done always 1: R-type 6 cycles, ld 8, st 8, jr 4, brx 7.
- Only one Zlowout/PCout/MDRout/Rout/Cout/Zhighout bus driver is active per cycle. Violation is a design error.

Test Plan:
- clear=1 for 2 cycles, then run=1, ir_op=00011 (add), mem_done=1 -> step sequence 0,1,2,3,4,5,0. T4 shows alu_op=00011, GRC, Rout, Zin. T5 shows Zlowout, GRA, Rin. No other strobes.
- ld (00000), mem_done low for 3 cycles in T6 -> step=6 held for 4 cycles with Read and MDRin steady. T7 follows with MDRout, GRA, Rin. Total 11 cycles.
- brx (10011) with CON_FF=0, then repeated with CON_FF=1 -> PCin is never asserted in the first run. In the second run PCin and Zlowout are asserted in T6.
- mem_done held 0 in T1 -> after 15 stalled cycles, mem_err=1, halted=1, step=15, all strobes 0. Subsequent run=1 has no effect until clear.
- halt (11011) -> halted=1 from the cycle after T3. clear=1 then returns step=14 with mem_err=0.
- clear asserted during st T7 (Write=1) -> Write=0 and step=14 on the next cycle. Undefined opcode 11111 -> T0–T3 only, no strobes in T3.
